// File: rtl/idx_list_ctrl_pkg.sv
// Shared definitions for the selected-atom index store and its sequencer.
// The register-file geometry lives here so the store, the sequencer and the
// bench all agree on it; the state encodings are exported for observability.
package idx_list_ctrl_pkg;

    // Index register file geometry.
    localparam int REG_IDX_ADDR_WIDTH = 4;
    localparam int REG_IDX_DATA_WIDTH = 8;
    localparam int REG_IDX_SIZE       = 16;

    // Sequencer state encodings.
    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_SCAN_RD_ENC  = 3'd1;
    localparam logic [2:0] ST_SCAN_CMP_ENC = 3'd2;
    localparam logic [2:0] ST_WRITE_ENC    = 3'd3;
    localparam logic [2:0] ST_RD_ISSUE_ENC = 3'd4;
    localparam logic [2:0] ST_RD_HOLD_ENC  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_SCAN_RD  = ST_SCAN_RD_ENC,
        ST_SCAN_CMP = ST_SCAN_CMP_ENC,
        ST_WRITE    = ST_WRITE_ENC,
        ST_RD_ISSUE = ST_RD_ISSUE_ENC,
        ST_RD_HOLD  = ST_RD_HOLD_ENC
    } state_e;

endpackage : idx_list_ctrl_pkg

// File: rtl/idx_list_ctrl.sv
// Sequencer for the selected-atom index store. Appends new column indices
// after scanning the stored entries for a duplicate, and streams the list
// back on request. It is the only driver of the store's single port, so the
// read and write strobes are mutually exclusive by construction (one state
// each) and both are low whenever the sequencer is idle.
module idx_list_ctrl
    import idx_list_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_IDX_ADDR_WIDTH,
    parameter int DATA_WIDTH = REG_IDX_DATA_WIDTH,
    parameter int DEPTH      = REG_IDX_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_idx,
    output logic                  push_ready,
    output logic                  push_done,
    output logic                  push_dup,
    input  logic                  rd_start,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  busy,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_e                  state_q,    state_d;
    logic [CNT_W-1:0]        count_q,    count_d;
    logic [ADDR_WIDTH-1:0]   scan_ptr_q, scan_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [DATA_WIDTH-1:0]   idx_q,      idx_d;

    logic                    idle_s;
    logic                    empty_s;
    logic                    abort_s;
    logic [CNT_W-1:0]        last_pos_s;
    logic                    scan_at_last_s;
    logic                    rd_at_last_s;
    logic                    scan_hit_s;

    // Status decode shared by the handshake outputs and the next-state logic.
    always_comb begin
        idle_s         = (state_q == ST_IDLE);
        empty_s        = (count_q == CNT_ZERO);
        // clear outside IDLE abandons whatever is in flight
        abort_s        = clear & ~idle_s;
        // position of the newest entry; only consulted while count is nonzero
        last_pos_s     = count_q - CNT_ONE;
        scan_at_last_s = ({1'b0, scan_ptr_q} == last_pos_s);
        rd_at_last_s   = ({1'b0, rd_ptr_q} == last_pos_s);
        scan_hit_s     = (mem_q == idx_q);
    end

    assign full       = (count_q == CNT_DEPTH);
    assign busy       = ~idle_s;
    assign count      = count_q;
    assign push_ready = idle_s & ~full & ~clear;
    // The store's read register already holds the entry stable between reads.
    assign out_data   = mem_q;

    // State, counter, pointer and latched-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= CNT_ZERO;
            scan_ptr_q <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            idx_q      <= DATA_ZERO;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            scan_ptr_q <= scan_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
        end
    end

    // Next-state and output decode; every output is quiet unless its state drives it.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        scan_ptr_d = scan_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;

        push_done  = 1'b0;
        push_dup   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        mem_addr   = PTR_ZERO;
        mem_d      = DATA_ZERO;

        if (abort_s) begin
            // aborted operation: no strobes, no completion, list emptied
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear) begin
                        count_d = CNT_ZERO;
                    end else if (push_valid && push_ready) begin
                        idx_d      = push_idx;
                        scan_ptr_d = PTR_ZERO;
                        if (empty_s) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_SCAN_RD;
                        end
                    end else if (rd_start && !empty_s) begin
                        rd_ptr_d = PTR_ZERO;
                        state_d  = ST_RD_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_SCAN_RD: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = scan_ptr_q;
                    state_d   = ST_SCAN_CMP;
                end

                ST_SCAN_CMP: begin
                    if (scan_hit_s) begin
                        push_done = 1'b1;
                        push_dup  = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (scan_at_last_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        scan_ptr_d = scan_ptr_q + PTR_ONE;
                        state_d    = ST_SCAN_RD;
                    end
                end

                ST_WRITE: begin
                    mem_wr_en = 1'b1;
                    mem_addr  = count_q[ADDR_WIDTH-1:0];
                    mem_d     = idx_q;
                    count_d   = count_q + CNT_ONE;
                    push_done = 1'b1;
                    push_dup  = 1'b0;
                    state_d   = ST_IDLE;
                end

                ST_RD_ISSUE: begin
                    mem_rd_en = 1'b1;
                    mem_addr  = rd_ptr_q;
                    state_d   = ST_RD_HOLD;
                end

                ST_RD_HOLD: begin
                    out_valid = 1'b1;
                    out_last  = rd_at_last_s;
                    if (out_ready) begin
                        if (rd_at_last_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                            state_d  = ST_RD_ISSUE;
                        end
                    end else begin
                        state_d = ST_RD_HOLD;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule : idx_list_ctrl

// File: tb/tb_idx_list_ctrl.sv
// Self-checking bench for idx_list_ctrl. The index store is modelled as a
// plain array with a registered read port; expected behaviour comes from a
// queue holding the ordered list of distinct indices.
module tb_idx_list_ctrl;
    import idx_list_ctrl_pkg::*;

    localparam int AW = REG_IDX_ADDR_WIDTH;
    localparam int DW = REG_IDX_DATA_WIDTH;
    localparam int DP = REG_IDX_SIZE;

    logic          clk = 1'b0;
    logic          rst, clear, push_valid, rd_start, out_ready;
    logic [DW-1:0] push_idx;
    logic          push_ready, push_done, push_dup;
    logic          out_valid, out_last, full, busy;
    logic [DW-1:0] out_data, mem_d;
    logic [DW-1:0] mem_q = '0;
    logic [AW:0]   count;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] store [DP];
    logic [DW-1:0] model [$];

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0, rd_cnt = 0, clash_cnt = 0;
    int last_wr_addr = 0, last_wr_data = 0, last_rd_addr = 0;

    idx_list_ctrl dut (
        .clk(clk), .rst(rst), .clear(clear),
        .push_valid(push_valid), .push_idx(push_idx), .push_ready(push_ready),
        .push_done(push_done), .push_dup(push_dup),
        .rd_start(rd_start), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready),
        .count(count), .full(full), .busy(busy),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Index store: synchronous write, registered read held until the next read.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            store[mem_addr] <= mem_d;
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = int'(mem_addr);
            last_wr_data = int'(mem_d);
        end
        if (mem_rd_en) begin
            mem_q <= store[mem_addr];
            rd_cnt       = rd_cnt + 1;
            last_rd_addr = int'(mem_addr);
        end
    end

    // Strobe exclusivity and quiet-when-idle monitor.
    always @(negedge clk) begin
        if (!rst && ((mem_wr_en && mem_rd_en) || (!busy && (mem_wr_en || mem_rd_en))))
            clash_cnt = clash_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    function automatic int find_pos(input logic [DW-1:0] v);
        for (int i = 0; i < model.size(); i++)
            if (model[i] == v) return i;
        return -1;
    endfunction

    // Offer v and wait for the accept handshake; returns 1 if accepted.
    task automatic offer(input logic [DW-1:0] v, output bit acc);
        int guard = 0;
        acc = 1'b0;
        push_valid = 1'b1;
        push_idx   = v;
        while (!acc && guard < 50) begin
            @(negedge clk);
            if (push_ready) acc = 1'b1;
            next_cycle();
            guard++;
        end
        push_valid = 1'b0;
        check_eq("push_accept", acc, 1);
    endtask

    task automatic do_push(input logic [DW-1:0] v);
        int  k, j, lat;
        bit  acc, done;
        logic dup_seen;
        k = model.size();
        j = find_pos(v);
        offer(v, acc);
        if (!acc) return;
        wr_cnt = 0; rd_cnt = 0; lat = 0; done = 1'b0; dup_seen = 1'b0;
        while (!done && lat < 80) begin
            lat++;
            @(negedge clk);
            if (push_done) begin
                done = 1'b1;
                dup_seen = push_dup;
            end
            next_cycle();
        end
        check_eq("push_done_seen", done, 1);
        if (j >= 0) begin
            check_eq("dup_latency", lat, 2 * (j + 1));
            check_eq("dup_flag", dup_seen, 1);
            check_eq("dup_writes", wr_cnt, 0);
            check_eq("dup_reads", rd_cnt, j + 1);
            check_eq("dup_last_rd_addr", last_rd_addr, j);
        end else begin
            check_eq("new_latency", lat, (k == 0) ? 1 : 2 * k + 1);
            check_eq("new_dup_flag", dup_seen, 0);
            check_eq("new_writes", wr_cnt, 1);
            check_eq("new_reads", rd_cnt, k);
            check_eq("new_wr_addr", last_wr_addr, k);
            check_eq("new_wr_data", last_wr_data, int'(v));
            model.push_back(v);
        end
        check_eq("push_count", int'(count), model.size());
        check_eq("push_idle", busy, 0);
    endtask

    task automatic do_stream(input bit always_ready);
        int n, i, cyc;
        n = model.size();
        rd_start = 1'b1;
        next_cycle();
        rd_start = 1'b0;
        if (n == 0) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check_eq("empty_rd_busy", busy, 0);
                check_eq("empty_rd_valid", out_valid, 0);
                next_cycle();
            end
            return;
        end
        i = 0; cyc = 0;
        while (i < n && cyc < 400) begin
            cyc++;
            out_ready = always_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (out_valid) begin
                check_eq("out_data", int'(out_data), int'(model[i]));
                check_eq("out_last", out_last, (i == n - 1) ? 1 : 0);
                if (out_ready) i++;
            end
            next_cycle();
        end
        out_ready = 1'b0;
        check_eq("stream_entries", i, n);
        if (always_ready) check_eq("stream_cycles", cyc, 2 * n);
        @(negedge clk);
        check_eq("stream_idle", busy, 0);
        check_eq("stream_valid_off", out_valid, 0);
        next_cycle();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        next_cycle();
        clear = 1'b0;
        model.delete();
        @(negedge clk);
        check_eq("clear_count", int'(count), 0);
        check_eq("clear_ready", push_ready, 1);
        next_cycle();
    endtask

    initial begin
        bit acc;
        rst = 1'b1; clear = 1'b0; push_valid = 1'b0; rd_start = 1'b0;
        out_ready = 1'b0; push_idx = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check_eq("rst_count", int'(count), 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_push_done", push_done, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_strobes", int'({mem_wr_en, mem_rd_en}), 0);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        check_eq("idle_push_ready", push_ready, 1);
        next_cycle();

        // Directed list build, duplicate, streaming.
        do_push(8'd5); do_push(8'd9); do_push(8'd3);
        do_push(8'd9);
        do_stream(1'b1);
        do_stream(1'b0);

        // Empty-list stream request is ignored.
        do_clear();
        do_stream(1'b1);

        // Fill to capacity, then a held offer must wait until clear.
        for (int v = 0; v < DP; v++) do_push(DW'(v));
        @(negedge clk);
        check_eq("full_flag", full, 1);
        check_eq("full_count", int'(count), DP);
        next_cycle();
        push_valid = 1'b1; push_idx = 8'd20;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("full_no_ready", push_ready, 0);
            check_eq("full_no_busy", busy, 0);
            next_cycle();
        end
        push_valid = 1'b0;
        do_clear();
        do_push(8'd20);

        // clear during the compare phase of a push aborts it.
        do_push(8'd7);
        offer(8'd11, acc);
        if (acc) begin
            next_cycle();
            clear = 1'b1;
            @(negedge clk);
            check_eq("abort_no_done", push_done, 0);
            check_eq("abort_no_write", mem_wr_en, 0);
            next_cycle();
            clear = 1'b0;
            @(negedge clk);
            check_eq("abort_idle", busy, 0);
            check_eq("abort_count", int'(count), 0);
            check_eq("abort_done_off", push_done, 0);
            next_cycle();
        end
        model.delete();

        // clear beats push and rd_start in IDLE.
        do_push(8'd1); do_push(8'd2);
        clear = 1'b1; push_valid = 1'b1; push_idx = 8'd4; rd_start = 1'b1;
        @(negedge clk);
        check_eq("prio_push_ready", push_ready, 0);
        next_cycle();
        clear = 1'b0; push_valid = 1'b0; rd_start = 1'b0;
        model.delete();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("prio_count", int'(count), 0);
            check_eq("prio_busy", busy, 0);
            check_eq("prio_no_stream", out_valid, 0);
            next_cycle();
        end

        // Randomized mix of operations against the list model.
        for (int op = 0; op < 80; op++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                if (model.size() == DP) do_clear();
                else do_push(DW'($urandom_range(0, 23)));
            end else if (r < 9) begin
                do_stream($urandom_range(0, 1) == 1);
            end else begin
                do_clear();
            end
        end

        check_eq("strobe_rules", clash_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_idx_list_ctrl
